regfile_port_scheduler: RTL and testbench
=========================================

// Module: regfile_port_scheduler
// PURPOSE
//  Shares the register file's single reg_code/data port between NREQ requesters (decode, load
//  unit, stack unit, debug). Grants one read or write per cycle, round-robin. A requester may
//  lock the port for an atomic read-modify-write sequence (e.g. sp update); the lock is bounded
//  by a timeout. Sits between the requesters and the register file; drives its wr/reg_code/data.
// PARAMETERS
//  NREQ      4    number of requesters (2..8)
//  DW        32   data width
//  AW        5    register code width; code 0 is the zero register
//  LOCK_MAX  8    max cycles the port stays LOCKED before forced release (>=2)
// PORTS
//  clk              in   1        clock
//  reset_b          in   1        async active-low reset
//  req_valid        in   NREQ     request pending, one bit per requester
//  req_we           in   NREQ     1=write, 0=read
//  req_lock         in   NREQ     keep the port after this transfer
//  req_code         in   NREQ*AW  register code, requester i at [i*AW +: AW]
//  req_wdata        in   NREQ*DW  write data, requester i at [i*DW +: DW]
//  req_ready        out  NREQ     one-hot grant, combinational; transfer = valid & ready
//  rsp_valid        out  NREQ     one-hot read-response pulse
//  rsp_data         out  DW       read data, shared by all requesters
//  rf_wr            out  1        write enable to register file
//  rf_reg_code      out  AW       register code to register file
//  rf_data          out  DW       write data to register file
//  rf_register_read in   DW       register file read data, combinational from rf_reg_code
//  zero_wr_err      out  1        1-cycle pulse: write to code 0 was rejected
//  lock_timeout     out  1        1-cycle pulse: lock force-released
// BEHAVIOUR
//  Reset: ptr=0, state=IDLE, lock_cnt=0, owner=0. rsp_valid, rsp_data, zero_wr_err and
//   lock_timeout are 0. Asserting reset mid-lock returns the block to IDLE and drops any pending
//   response.
//  Grant: IDLE grants the first i with req_valid[i], searching ptr, ptr+1, ... mod NREQ.
//   LOCKED grants only owner; all other requesters stall. At most one req_ready bit is high.
//   req_ready may depend on req_valid but not on req_we, req_lock or req_code.
//  Port drive: with no grant, rf_wr=0, rf_reg_code=0 and rf_data=0. With a grant, rf_reg_code
//   and rf_data come from the granted requester, and rf_wr = req_we & (code!=0).
//  Read: at the edge, rsp_data <= rf_register_read and rsp_valid[i] <= 1 for one cycle. Latency
//   is 1 cycle. rsp_data holds its value until the next read.
//  Write: the register file updates at the same edge. No response is produced. A read granted
//   in the next cycle returns the new value.
//  Zero write: the handshake completes (ready=1) but rf_wr=0; zero_wr_err pulses the next cycle.
//  Round-robin: after a transfer by i with the port not remaining locked, ptr <= (i+1) mod NREQ.
//   ptr is unchanged while LOCKED.
//  FSM:
//   IDLE->LOCKED on a transfer with req_lock=1; set owner=i, lock_cnt=1.
//   LOCKED->LOCKED on an owner transfer with lock=1, or on an idle cycle; lock_cnt++.
//   LOCKED->IDLE on an owner transfer with lock=0; ptr advances past the owner.
//   LOCKED->IDLE when lock_cnt==LOCK_MAX, whether or not the owner transfers that cycle. That
//    transfer completes, then lock_timeout pulses the next cycle and ptr advances past the owner.
//  Requesters hold valid/we/lock/code/wdata stable until ready. A requester must not drop valid
//   before its grant.
// TESTING
//  1. Reset, then req0 read code 2 (rf value 0x100).
//     -> ready[0] in the same cycle; rsp_valid[0]=1 and rsp_data=0x100 in the next cycle.
//  2. All 4 requesters valid continuously from ptr=0.
//     -> grant order 0,1,2,3,0,...; each gets exactly 1 of every 4 cycles.
//  3. req1 writes 0xDEAD to code 5, then req1 reads code 5 in the next cycle.
//     -> rf_wr=1 with rf_reg_code=5; the read returns 0xDEAD.
//  4. req2 writes to code 0.
//     -> ready[2]=1, rf_wr=0, zero_wr_err pulses 1 cycle later; rf contents unchanged.
//  5. req3 read code 2 with lock=1, then write code 2 with lock=0, while req0 is valid.
//     -> req0 stalls 2 cycles; the next grant goes to req0; ptr=0 after release.
//  6. req1 locks and holds lock=1 with LOCK_MAX=8.
//     -> forced release at lock_cnt=8 and lock_timeout pulses; reset_b low mid-lock gives
//        IDLE, ptr=0 and all outputs 0.

Source files
------------

// File: rtl/regfile_port_scheduler.sv
// regfile_port_scheduler: round-robin arbiter for the single register-file port, with a bounded lock for read-modify-write sequences
module regfile_port_scheduler #(
    parameter int NREQ     = 4,
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ-1:0]   req_lock,
    input  logic [NREQ*AW-1:0] req_code,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_data,
    output logic              rf_wr,
    output logic [AW-1:0]     rf_reg_code,
    output logic [DW-1:0]     rf_data,
    input  logic [DW-1:0]     rf_register_read,
    output logic              zero_wr_err,
    output logic              lock_timeout
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, ptr_nx, owner, owner_nx, gidx;
    logic [CW-1:0]   lock_cnt, lock_cnt_nx;
    logic [PW:0]     sum;
    logic            xfer, g_we, g_lock, timeout;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] v);
        return (v == PW'(NREQ - 1)) ? '0 : v + PW'(1);
    endfunction

    // grant: owner only while locked, else first valid requester searching from ptr
    always_comb begin
        gidx = '0;
        xfer = 1'b0;
        sum  = '0;
        if (state == LOCKED) begin
            gidx = owner;
            xfer = req_valid[owner];
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                sum = {1'b0, ptr} + (PW + 1)'(k);
                if (sum >= (PW + 1)'(NREQ)) sum = sum - (PW + 1)'(NREQ);
                if (req_valid[sum[PW-1:0]]) begin
                    gidx = sum[PW-1:0];
                    xfer = 1'b1;
                end
            end
        end
        req_ready       = '0;
        req_ready[gidx] = xfer;
    end

    // drive the register-file port from the granted requester; zero register is never written
    always_comb begin
        rf_reg_code = '0;
        rf_data     = '0;
        g_we        = 1'b0;
        g_lock      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                rf_reg_code = req_code[i*AW +: AW];
                rf_data     = req_wdata[i*DW +: DW];
                g_we        = req_we[i];
                g_lock      = req_lock[i];
            end
        end
        rf_wr = g_we & (rf_reg_code != '0);
    end

    // lock FSM and round-robin pointer update
    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        owner_nx    = owner;
        lock_cnt_nx = lock_cnt;
        timeout     = (state == LOCKED) && (lock_cnt == CW'(LOCK_MAX));
        if (state == IDLE) begin
            if (xfer && g_lock) begin
                state_nx    = LOCKED;
                owner_nx    = gidx;
                lock_cnt_nx = CW'(1);
            end else if (xfer) begin
                ptr_nx = inc(gidx);
            end
        end else if (timeout || (xfer && !g_lock)) begin
            state_nx    = IDLE;
            ptr_nx      = inc(owner);
            lock_cnt_nx = '0;
        end else begin
            lock_cnt_nx = lock_cnt + CW'(1);
        end
    end

    // state registers, read response capture and error pulses
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state        <= IDLE;
            ptr          <= '0;
            owner        <= '0;
            lock_cnt     <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            zero_wr_err  <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            state        <= state_nx;
            ptr          <= ptr_nx;
            owner        <= owner_nx;
            lock_cnt     <= lock_cnt_nx;
            rsp_valid    <= (xfer && !g_we) ? req_ready : '0;
            if (xfer && !g_we) rsp_data <= rf_register_read;
            zero_wr_err  <= xfer && g_we && (rf_reg_code == '0);
            lock_timeout <= timeout;
        end
    end
endmodule

// File: tb/tb_regfile_port_scheduler.sv
// tb_regfile_port_scheduler: vector table, directed lock sequences and a model-based scoreboard for the port scheduler
module tb_regfile_port_scheduler;
    localparam int NREQ = 4, DW = 32, AW = 5, LOCK_MAX = 8;

    logic clk = 1'b0;
    logic reset_b;
    logic [NREQ-1:0] req_valid, req_we, req_lock, req_ready, rsp_valid;
    logic [NREQ*AW-1:0] req_code;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0] rsp_data, rf_data, rf_register_read;
    logic [AW-1:0] rf_reg_code;
    logic rf_wr, zero_wr_err, lock_timeout;

    int checks = 0;
    int errors = 0;

    regfile_port_scheduler #(.NREQ(NREQ), .DW(DW), .AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset_b(reset_b), .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_code(req_code), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rf_wr(rf_wr), .rf_reg_code(rf_reg_code), .rf_data(rf_data),
        .rf_register_read(rf_register_read), .zero_wr_err(zero_wr_err), .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    // register file environment: reloads code*0x80 while in reset
    logic [DW-1:0] rf [32];
    always @(posedge clk) begin
        if (!reset_b) begin
            for (int i = 0; i < 32; i++) rf[i] <= DW'(i * 128);
        end else if (rf_wr) begin
            rf[rf_reg_code] <= rf_data;
        end
    end
    assign rf_register_read = rf[rf_reg_code];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model and scoreboard, sampled mid-cycle
    typedef struct { int idx; logic [DW-1:0] data; } exp_t;
    exp_t q[$];
    logic [DW-1:0] exp_rf [32];
    int m_ptr, m_owner, m_cnt, g;
    logic m_locked, m_zerr, m_to, we, lk;
    logic [DW-1:0] m_rdata, wd;
    logic [AW-1:0] code;
    exp_t e;

    always @(negedge clk) begin
        if (!reset_b) begin
            m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0; m_zerr = 0; m_to = 0; m_rdata = '0;
            q.delete();
            for (int i = 0; i < 32; i++) exp_rf[i] = DW'(i * 128);
        end else begin
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_rsp_valid", rsp_valid, 64'(1) << e.idx);
                chk("sb_rsp_data", rsp_data, e.data);
                m_rdata = e.data;
            end else begin
                chk("sb_rsp_idle", rsp_valid, 0);
                chk("sb_rsp_hold", rsp_data, m_rdata);
            end
            chk("sb_zero_wr_err", zero_wr_err, m_zerr);
            chk("sb_lock_timeout", lock_timeout, m_to);
            g = -1;
            if (m_locked) begin
                if (req_valid[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < NREQ; k++) if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
            chk("sb_ready", req_ready, g < 0 ? 0 : 64'(1) << g);
            code = '0; wd = '0; we = 0; lk = 0;
            if (g >= 0) begin
                code = req_code[g*AW +: AW]; wd = req_wdata[g*DW +: DW]; we = req_we[g]; lk = req_lock[g];
            end
            chk("sb_rf_wr", rf_wr, we && code != 0);
            chk("sb_rf_reg_code", rf_reg_code, code);
            chk("sb_rf_data", rf_data, wd);
            m_zerr = (g >= 0) && we && code == 0;
            m_to = m_locked && m_cnt == LOCK_MAX;
            if (g >= 0 && !we) q.push_back('{g, exp_rf[code]});
            if (g >= 0 && we && code != 0) exp_rf[code] = wd;
            if (!m_locked) begin
                if (g >= 0 && lk) begin m_locked = 1; m_owner = g; m_cnt = 1; end
                else if (g >= 0) m_ptr = (g + 1) % NREQ;
            end else if (m_to || (g >= 0 && !lk)) begin
                m_locked = 0; m_ptr = (m_owner + 1) % NREQ; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic w, input logic l,
                           input logic [AW-1:0] c, input logic [DW-1:0] d);
        req_valid[i] = v; req_we[i] = w; req_lock[i] = l;
        req_code[i*AW +: AW] = c; req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        req_valid = '0; req_we = '0; req_lock = '0; req_code = '0; req_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset_b = 1'b0;
        clear_all();
        tick();
        reset_b = 1'b1;
    endtask

    typedef struct {
        logic [NREQ-1:0] valid, we, ready;
        logic [AW-1:0] code;
        logic [DW-1:0] wdata;
    } vec_t;
    vec_t tbl [14];

    initial begin
        tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 5'd2, 32'h0};
        tbl[1]  = '{4'b1111, 4'b0000, 4'b0010, 5'd2, 32'h0};
        tbl[2]  = '{4'b1111, 4'b0000, 4'b0100, 5'd2, 32'h0};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b1000, 5'd2, 32'h0};
        tbl[4]  = '{4'b1111, 4'b0000, 4'b0001, 5'd2, 32'h0};
        tbl[5]  = '{4'b1010, 4'b1010, 4'b0010, 5'd7, 32'h77};
        tbl[6]  = '{4'b0011, 4'b0000, 4'b0001, 5'd7, 32'h0};
        tbl[7]  = '{4'b1000, 4'b0000, 4'b1000, 5'd3, 32'h0};
        tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 5'd3, 32'h0};
        tbl[9]  = '{4'b1100, 4'b0000, 4'b0100, 5'd4, 32'h0};
        tbl[10] = '{4'b0101, 4'b0000, 4'b0001, 5'd4, 32'h0};
        tbl[11] = '{4'b0100, 4'b0100, 4'b0100, 5'd0, 32'h99};
        tbl[12] = '{4'b0110, 4'b0000, 4'b0010, 5'd0, 32'h0};
        tbl[13] = '{4'b1111, 4'b0000, 4'b0100, 5'd7, 32'h0};

        reset_b = 1'b0;
        clear_all();
        #2;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_zero_wr_err", zero_wr_err, 0);
        chk("reset_lock_timeout", lock_timeout, 0);
        repeat (3) @(posedge clk);
        #1 reset_b = 1'b1;

        // single read after reset
        tick(); set_req(0, 1, 0, 0, 5'd2, 0); #2;
        chk("t1_ready", req_ready, 4'b0001);
        chk("t1_code", rf_reg_code, 2);
        tick(); clear_all(); #2;
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_rsp_data", rsp_data, 32'h100);

        // write then read back
        tick(); set_req(1, 1, 1, 0, 5'd5, 32'hDEAD); #2;
        chk("t3_ready_wr", req_ready, 4'b0010);
        chk("t3_rf_wr", rf_wr, 1);
        chk("t3_rf_code", rf_reg_code, 5);
        tick(); set_req(1, 1, 0, 0, 5'd5, 0); #2;
        chk("t3_ready_rd", req_ready, 4'b0010);
        tick(); clear_all(); #2;
        chk("t3_rsp_valid", rsp_valid, 4'b0010);
        chk("t3_rsp_data", rsp_data, 32'hDEAD);

        // write to the zero register
        tick(); set_req(2, 1, 1, 0, 5'd0, 32'h55); #2;
        chk("t4_ready", req_ready, 4'b0100);
        chk("t4_rf_wr", rf_wr, 0);
        tick(); clear_all(); #2;
        chk("t4_zero_err", zero_wr_err, 1);
        tick(); #2;
        chk("t4_zero_err_end", zero_wr_err, 0);
        chk("t4_rf0", rf[0], 0);

        // vector table from ptr=0
        do_reset();
        for (int i = 0; i < 14; i++) begin
            tick();
            for (int r = 0; r < NREQ; r++) set_req(r, tbl[i].valid[r], tbl[i].we[r], 0, tbl[i].code, tbl[i].wdata);
            #2;
            chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].ready);
        end
        tick(); clear_all();

        // locked read-modify-write by req3 while req0 waits
        do_reset();
        tick(); set_req(2, 1, 0, 0, 5'd1, 0); #2;
        chk("t5_pre", req_ready, 4'b0100);
        tick(); set_req(2, 0, 0, 0, 0, 0); set_req(3, 1, 0, 1, 5'd2, 0); set_req(0, 1, 0, 0, 5'd1, 0); #2;
        chk("t5_lock_rd", req_ready, 4'b1000);
        tick(); set_req(3, 1, 1, 0, 5'd2, 32'h222); #2;
        chk("t5_lock_wr", req_ready, 4'b1000);
        chk("t5_rsp_valid", rsp_valid, 4'b1000);
        chk("t5_rsp_data", rsp_data, 32'h100);
        tick(); set_req(3, 0, 0, 0, 0, 0); #2;
        chk("t5_req0", req_ready, 4'b0001);
        tick(); set_req(0, 0, 0, 0, 0, 0); set_req(1, 1, 0, 0, 5'd2, 0); #2;
        chk("t5_rsp0", rsp_valid, 4'b0001);
        chk("t5_ptr_after", req_ready, 4'b0010);
        tick(); clear_all(); #2;
        chk("t5_rmw_data", rsp_data, 32'h222);

        // lock held past LOCK_MAX: forced release
        tick(); set_req(1, 1, 0, 1, 5'd3, 0); #2;
        chk("t6_lock", req_ready, 4'b0010);
        for (int c = 2; c <= LOCK_MAX + 1; c++) begin
            tick(); set_req(2, 1, 0, 0, 5'd4, 0); #2;
            chk($sformatf("t6_hold%0d", c), req_ready, 4'b0010);
            chk($sformatf("t6_to%0d", c), lock_timeout, 0);
        end
        tick(); #2;
        chk("t6_release", req_ready, 4'b0100);
        chk("t6_timeout", lock_timeout, 1);
        tick(); set_req(2, 0, 0, 0, 0, 0); #2;
        chk("t6_relock", req_ready, 4'b0010);
        chk("t6_timeout_end", lock_timeout, 0);
        tick(); #2;
        chk("t6_locked_again", req_ready, 4'b0010);
        tick(); reset_b = 1'b0; clear_all(); #2;
        chk("t6_rst_ready", req_ready, 0);
        chk("t6_rst_rf_wr", rf_wr, 0);
        chk("t6_rst_code", rf_reg_code, 0);
        chk("t6_rst_data", rf_data, 0);
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        chk("t6_rst_rsp_data", rsp_data, 0);
        chk("t6_rst_zerr", zero_wr_err, 0);
        chk("t6_rst_to", lock_timeout, 0);
        tick(); reset_b = 1'b1;
        for (int r = 0; r < NREQ; r++) set_req(r, 1, 0, 0, 5'd1, 0);
        #2;
        chk("t6_ptr0", req_ready, 4'b0001);
        tick(); clear_all();
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
